// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART TX arbiter: FSM encoding, byte width,
// and the round-robin wrap used when a grant is released.
package uart_tx_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

  localparam int UART_BYTE_W = 8;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above i_ptr,
// wrapping past the top index back to zero.
module uart_tx_arbiter_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int REQ_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [REQ_W-1:0]   i_ptr,
  output logic               o_found,
  output logic [REQ_W-1:0]   o_idx
);

  // Walk offsets from the pointer; the first hit is kept, later hits are ignored.
  always_comb begin
    int unsigned c;
    logic [REQ_W-1:0] w_cand;
    o_found = 1'b0;
    o_idx   = {REQ_W{1'b0}};
    for (int unsigned off = 0; off < 32'(NUM_REQ); off++) begin
      c      = 32'(i_ptr) + off;
      c      = (c >= 32'(NUM_REQ)) ? (c - 32'(NUM_REQ)) : c;
      w_cand = REQ_W'(c);
      o_idx   = (!o_found && i_req[w_cand]) ? w_cand : o_idx;
      o_found = o_found | i_req[w_cand];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet lock that shares one UART TX serializer
// between NUM_REQ valid/ready byte streams.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int REQ_W     = 1,
  parameter int MAX_BURST = 16,
  parameter int STALL_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx_valid,
  output logic [UART_BYTE_W-1:0]       tx_data,
  input  logic                         tx_ready,
  output logic                         grant_active,
  output logic [REQ_W-1:0]             grant_id
);

  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int STALL_W = $clog2(STALL_CYC + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYC - 1);
  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

  arb_state_e           r_state;
  arb_state_e           w_state_nxt;
  logic [REQ_W-1:0]     r_grant_id;
  logic [REQ_W-1:0]     w_grant_id_nxt;
  logic [REQ_W-1:0]     r_rr_ptr;
  logic [REQ_W-1:0]     w_rr_ptr_nxt;
  logic [BURST_W-1:0]   r_burst_cnt;
  logic [BURST_W-1:0]   w_burst_nxt;
  logic [STALL_W-1:0]   r_stall_cnt;
  logic [STALL_W-1:0]   w_stall_nxt;

  logic                 w_found;
  logic [REQ_W-1:0]     w_pick_idx;
  logic                 w_in_xfer;
  logic                 w_hold_valid;
  logic                 w_hold_last;
  logic [UART_BYTE_W-1:0] w_hold_data;
  logic                 w_xfer;
  logic                 w_release;

  uart_tx_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .REQ_W   (REQ_W)
  ) u_picker (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick_idx)
  );

  // Holder's byte passes straight through; non-holders are never looked at.
  assign w_in_xfer    = (r_state == ARB_XFER);
  assign w_hold_valid = req_valid[r_grant_id];
  assign w_hold_last  = req_last[r_grant_id];
  assign w_hold_data  = req_data[{r_grant_id, 3'b000} +: UART_BYTE_W];
  assign tx_valid     = w_in_xfer & w_hold_valid;
  assign tx_data      = w_in_xfer ? w_hold_data : {UART_BYTE_W{1'b0}};
  assign w_xfer       = tx_valid & tx_ready;
  assign grant_active = w_in_xfer;
  assign grant_id     = r_grant_id;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ready
    assign req_ready[g] = w_xfer & (r_grant_id == REQ_W'(g));
  end

  // Next-state, grant, pointer and counter updates.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_id_nxt = r_grant_id;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_burst_nxt    = r_burst_cnt;
    w_stall_nxt    = r_stall_cnt;
    w_release      = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        w_burst_nxt = {BURST_W{1'b0}};
        w_stall_nxt = {STALL_W{1'b0}};
        if (w_found) begin
          w_state_nxt    = ARB_XFER;
          w_grant_id_nxt = w_pick_idx;
        end else begin
          w_state_nxt    = ARB_IDLE;
        end
      end
      ARB_XFER: begin
        if (w_xfer) begin
          w_burst_nxt = r_burst_cnt + BURST_ONE;
        end else begin
          w_burst_nxt = r_burst_cnt;
        end
        if (w_xfer || w_hold_valid) begin
          w_stall_nxt = {STALL_W{1'b0}};
        end else if (r_stall_cnt != STALL_MAX) begin
          w_stall_nxt = r_stall_cnt + STALL_ONE;
        end else begin
          w_stall_nxt = r_stall_cnt;
        end
        // Last byte and burst cap together still make a single release.
        w_release = (w_xfer && (w_hold_last || ((r_burst_cnt + BURST_ONE) == BURST_MAX))) ||
                    (!w_hold_valid && (r_stall_cnt == STALL_MAX));
        if (w_release) begin
          w_state_nxt  = ARB_IDLE;
          w_rr_ptr_nxt = REQ_W'(rr_next(32'(r_grant_id), 32'(NUM_REQ)));
        end else begin
          w_state_nxt  = ARB_XFER;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_grant_id  <= {REQ_W{1'b0}};
      r_rr_ptr    <= {REQ_W{1'b0}};
      r_burst_cnt <= {BURST_W{1'b0}};
      r_stall_cnt <= {STALL_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_grant_id  <= w_grant_id_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_stall_cnt <= w_stall_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte-queue requesters, a capturing
// serializer sink, and hand-written expected byte/grant orders.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        grant_active;
  logic [0:0]  grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ   (2),
    .REQ_W     (1),
    .MAX_BURST (16),
    .STALL_CYC (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .grant_active (grant_active),
    .grant_id     (grant_id)
  );

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] log_q[$];
  logic [8:0] exp_q[$];
  int         gcyc_q[$];
  logic       gid_q[$];
  logic [1:0] en;
  logic [1:0] pop;
  logic       prev_ga;
  int         txr_period;
  int         cyc;
  int         n_tests;
  int         n_fail;
  int         viol;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    req_valid[0]  = en[0] && (q0.size() != 0);
    req_data[7:0] = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
    req_last[0]   = (q0.size() != 0) ? q0[0][8] : 1'b0;
    req_valid[1]  = en[1] && (q1.size() != 0);
    req_data[15:8] = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
    req_last[1]   = (q1.size() != 0) ? q1[0][8] : 1'b0;
    tx_ready      = ((cyc % txr_period) == 0);
  endtask

  // Just after the edge: retire bytes accepted at that edge, present next inputs.
  task automatic tick_pre();
    @(posedge clk);
    #1;
    if (pop[0] && q0.size() != 0) void'(q0.pop_front());
    if (pop[1] && q1.size() != 0) void'(q1.pop_front());
    pop = 2'b00;
    cyc++;
    drive_inputs();
  endtask

  task automatic tick_obs();
    @(negedge clk);
    pop = req_ready;
    if (tx_valid && tx_ready) begin
      log_q.push_back({grant_id, tx_data});
      if (req_ready != (2'b01 << grant_id)) viol++;
    end else if (req_ready != 2'b00) begin
      viol++;
    end
    if (grant_active && !prev_ga) begin
      gcyc_q.push_back(cyc);
      gid_q.push_back(grant_id[0]);
    end
    prev_ga = grant_active;
  endtask

  task automatic tick();
    tick_pre();
    tick_obs();
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int k;
    k = 0;
    while ((q0.size() != 0 || q1.size() != 0 || grant_active) && k < max_cyc) begin
      tick();
      k++;
    end
    check_val($sformatf("%s_timeout", tag), 32'(k < max_cyc), 32'd1);
  endtask

  task automatic push_src(input int who, input logic [7:0] base, input int n, input logic last_end);
    logic [8:0] e;
    for (int k = 0; k < n; k++) begin
      e = {last_end && (k == n - 1), base + 8'(k)};
      if (who == 0) q0.push_back(e);
      else          q1.push_back(e);
    end
  endtask

  task automatic push_exp(input logic gid, input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({gid, base + 8'(k)});
  endtask

  task automatic chk_log(input string tag);
    check_val($sformatf("%s_len", tag), 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      check_val($sformatf("%s[%0d]", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sv;
    rst = 1'b1; req_valid = 2'b00; req_data = 16'h0000; req_last = 2'b00; tx_ready = 1'b0;
    en = 2'b11; pop = 2'b00; prev_ga = 1'b0; txr_period = 1; cyc = 0;
    n_tests = 0; n_fail = 0; viol = 0;

    // 1) single 3-byte packet from req0; request already pending while in reset
    push_src(0, 8'h41, 3, 1'b1);
    repeat (3) tick();
    check_val("rst_ga", 32'(grant_active), 32'd0);
    check_val("rst_txv", 32'(tx_valid), 32'd0);
    check_val("rst_rdy", 32'(req_ready), 32'd0);
    check_val("rst_gid", 32'(grant_id), 32'd0);
    rst = 1'b0;
    tick();
    check_val("t1_ga", 32'(grant_active), 32'd1);
    check_val("t1_gid", 32'(grant_id), 32'd0);
    check_val("t1_txv", 32'(tx_valid), 32'd1);
    check_val("t1_txd", 32'(tx_data), 32'h41);
    repeat (3) tick();
    check_val("t1_release", 32'(grant_active), 32'd0);
    push_exp(1'b0, 8'h41, 3);
    chk_log("t1_data");

    // rr_ptr now 1: simultaneous requests must favour req1
    push_src(0, 8'h50, 1, 1'b1);
    push_src(1, 8'h60, 1, 1'b1);
    tick();
    check_val("t1_idle", 32'(grant_active), 32'd0);
    tick();
    check_val("t1_rr_gid", 32'(grant_id), 32'd1);
    tick();
    check_val("t1_gap", 32'(grant_active), 32'd0);
    tick();
    check_val("t1_rr_next", 32'(grant_id), 32'd0);
    wait_idle("t1", 20);
    push_exp(1'b1, 8'h60, 1);
    push_exp(1'b0, 8'h50, 1);
    chk_log("t1_rr_data");

    // 2) both requesters ready at reset exit
    rst = 1'b1;
    tick();
    push_src(0, 8'hA0, 2, 1'b1);
    push_src(1, 8'hB0, 2, 1'b1);
    tick();
    rst = 1'b0;
    gcyc_q.delete(); gid_q.delete();
    wait_idle("t2", 40);
    push_exp(1'b0, 8'hA0, 2);
    push_exp(1'b1, 8'hB0, 2);
    chk_log("t2_data");
    check_val("t2_ngrant", 32'(gid_q.size()), 32'd2);
    if (gid_q.size() >= 2) begin
      check_val("t2_first", 32'(gid_q[0]), 32'd0);
      check_val("t2_second", 32'(gid_q[1]), 32'd1);
      check_val("t2_spacing", 32'(gcyc_q[1] - gcyc_q[0]), 32'd3);
    end

    // 3) req1 streams 20 bytes without last; burst cap hands over to req0
    gcyc_q.delete(); gid_q.delete();
    push_src(1, 8'h80, 20, 1'b0);
    tick();
    push_src(0, 8'hC0, 2, 1'b1);
    wait_idle("t3", 120);
    push_exp(1'b1, 8'h80, 16);
    push_exp(1'b0, 8'hC0, 2);
    push_exp(1'b1, 8'h90, 4);
    chk_log("t3_data");
    check_val("t3_ngrant", 32'(gid_q.size()), 32'd3);
    if (gid_q.size() >= 3) begin
      check_val("t3_g0", 32'(gid_q[0]), 32'd1);
      check_val("t3_g1", 32'(gid_q[1]), 32'd0);
      check_val("t3_g2", 32'(gid_q[2]), 32'd1);
    end

    // 4) holder stalls after one byte; lock held for STALL_CYC cycles
    push_src(0, 8'h11, 2, 1'b1);
    push_src(1, 8'h21, 1, 1'b1);
    tick();
    tick();
    check_val("t4_gid", 32'(grant_id), 32'd0);
    check_val("t4_txd", 32'(tx_data), 32'h11);
    en[0] = 1'b0;
    sv = 0;
    repeat (8) begin
      tick();
      if (!grant_active || tx_valid || (req_ready != 2'b00) || (grant_id != 1'b0)) sv++;
    end
    check_val("t4_hold", 32'(sv), 32'd0);
    tick();
    check_val("t4_release", 32'(grant_active), 32'd0);
    tick();
    check_val("t4_next_ga", 32'(grant_active), 32'd1);
    check_val("t4_next_gid", 32'(grant_id), 32'd1);
    en[0] = 1'b1;
    wait_idle("t4", 40);
    push_exp(1'b0, 8'h11, 1);
    push_exp(1'b1, 8'h21, 1);
    push_exp(1'b0, 8'h12, 1);
    chk_log("t4_data");

    // 5) serializer accepts one byte in four
    check_val("inv_pre5", 32'(viol), 32'd0);
    txr_period = 4;
    push_src(0, 8'h30, 5, 1'b1);
    push_src(1, 8'h70, 5, 1'b1);
    wait_idle("t5", 200);
    push_exp(1'b1, 8'h70, 5);
    push_exp(1'b0, 8'h30, 5);
    chk_log("t5_data");
    check_val("t5_ready_only_on_xfer", 32'(viol), 32'd0);

    // 6) reset after byte 2 of 5; rr_ptr (was 1) must restart at 0
    txr_period = 1;
    push_src(0, 8'hD0, 5, 1'b1);
    tick();
    tick();
    check_val("t6_gid", 32'(grant_id), 32'd0);
    tick();
    tick_pre();
    rst = 1'b1;
    #1;
    check_val("t6_rst_ga", 32'(grant_active), 32'd0);
    check_val("t6_rst_txv", 32'(tx_valid), 32'd0);
    check_val("t6_rst_rdy", 32'(req_ready), 32'd0);
    tick_obs();
    push_src(1, 8'hE0, 1, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    check_val("t6_regrant_ga", 32'(grant_active), 32'd1);
    check_val("t6_regrant_gid", 32'(grant_id), 32'd0);
    wait_idle("t6", 40);
    push_exp(1'b0, 8'hD0, 5);
    push_exp(1'b1, 8'hE0, 1);
    chk_log("t6_data");
    check_val("inv_final", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
